cdp_dp_div_unit: RTL and testbench

Iterative signed integer divider for the CDP datapath. It is the inverse-direction companion of the CDP signed multiply unit: it divides a wide signed product-width numerator by a signed denominator. Input and output each use a valid/ready handshake. It sits between the LRN sum/scale stage and the output converter. One operation is in flight at a time, and the block produces one quotient bit per cycle using restoring division on magnitudes.

---
 rtl/cdp_dp_div_unit.sv | 157 +++++++++++++++
 tb/tb_cdp_dp_div_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/cdp_dp_div_unit.sv
// Iterative signed restoring divider: one quotient bit per cycle, fixed latency pNUM_BW+1.
// Optional round-half-away-from-zero when CDP_DIV_ROUND_EN is defined; truncation otherwise.
module cdp_dp_div_unit #(
  parameter int pNUM_BW = 25,
  parameter int pDEN_BW = 16
) (
  input  logic               nvdla_core_clk,
  input  logic               nvdla_core_rst,
  input  logic               div_vld,
  output logic               div_rdy,
  input  logic [pNUM_BW-1:0] div_num_pd,
  input  logic [pDEN_BW-1:0] div_den_pd,
  output logic               div_unit_vld,
  input  logic               div_unit_rdy,
  output logic [pNUM_BW-1:0] div_unit_pd,
  output logic [pDEN_BW-1:0] div_unit_rem,
  output logic               div_unit_dz,
  output logic               div_unit_sat
);

  localparam int CntW = $clog2(pNUM_BW);
  localparam logic [pNUM_BW+1:0] QMax = {3'b000, {(pNUM_BW-1){1'b1}}};
  localparam logic [pNUM_BW+1:0] QMin = {3'b111, {(pNUM_BW-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e state_q, state_d;

  // num_q shifts numerator bits out of the top while quotient bits enter at the bottom.
  logic [pNUM_BW-1:0] num_q;
  logic [pDEN_BW-1:0] den_q;
  logic [pDEN_BW-1:0] rem_q;
  logic [CntW-1:0]    cnt_q;
  logic               sign_q;
  logic               nsign_q;
  logic               dz_q;

  logic [pNUM_BW-1:0] pd_q;
  logic [pDEN_BW-1:0] rem_out_q;
  logic               dz_out_q;
  logic               sat_q;

  logic [pNUM_BW-1:0] num_abs;
  logic [pDEN_BW-1:0] den_abs;
  logic [pDEN_BW:0]   partial;
  logic               ge;
  logic [pDEN_BW-1:0] rem_step;
  logic [pNUM_BW-1:0] num_step;

  logic               rnd;
  logic [pNUM_BW:0]   qmag;
  logic [pNUM_BW+1:0] q_full;
  logic [pDEN_BW-1:0] rem_mag;
  logic [pNUM_BW-1:0] fix_q;
  logic [pDEN_BW-1:0] fix_rem;
  logic               fix_sat;

  assign div_rdy      = (state_q == StIdle);
  assign div_unit_vld = (state_q == StDone);
  assign div_unit_pd  = pd_q;
  assign div_unit_rem = rem_out_q;
  assign div_unit_dz  = dz_out_q;
  assign div_unit_sat = sat_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (div_vld) state_d = StCalc;
      StCalc:  if (cnt_q == '0) state_d = StFix;
      StFix:   state_d = StDone;
      StDone:  if (div_unit_rdy) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    num_abs  = div_num_pd[pNUM_BW-1] ? (~div_num_pd + 1'b1) : div_num_pd;
    den_abs  = div_den_pd[pDEN_BW-1] ? (~div_den_pd + 1'b1) : div_den_pd;
    partial  = {rem_q, num_q[pNUM_BW-1]};
    ge       = (partial >= {1'b0, den_q});
    rem_step = ge ? (partial[pDEN_BW-1:0] - den_q) : partial[pDEN_BW-1:0];
    num_step = {num_q[pNUM_BW-2:0], ge};
  end

  always_comb begin
`ifdef CDP_DIV_ROUND_EN
    rnd = ({rem_q, 1'b0} >= {1'b0, den_q});
`else
    rnd = 1'b0;
`endif
    qmag    = {1'b0, num_q} + {{pNUM_BW{1'b0}}, rnd};
    q_full  = sign_q ? (~{1'b0, qmag} + 1'b1) : {1'b0, qmag};
    // Rounding up flips the remainder to the side opposite the numerator.
    rem_mag = rnd ? (den_q - rem_q) : rem_q;
    fix_rem = (nsign_q ^ rnd) ? (~rem_mag + 1'b1) : rem_mag;
    fix_sat = 1'b0;
    fix_q   = q_full[pNUM_BW-1:0];
    // Clamping keeps the remainder of the exact quotient (0 for the MIN/-1 case).
    if ($signed(q_full) > $signed(QMax)) begin
      fix_q   = QMax[pNUM_BW-1:0];
      fix_sat = 1'b1;
    end else if ($signed(q_full) < $signed(QMin)) begin
      fix_q   = QMin[pNUM_BW-1:0];
      fix_sat = 1'b1;
    end
    if (dz_q) begin
      fix_q   = nsign_q ? QMin[pNUM_BW-1:0] : QMax[pNUM_BW-1:0];
      fix_rem = '0;
      fix_sat = 1'b0;
    end
  end

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      state_q   <= StIdle;
      num_q     <= '0;
      den_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      sign_q    <= 1'b0;
      nsign_q   <= 1'b0;
      dz_q      <= 1'b0;
      pd_q      <= '0;
      rem_out_q <= '0;
      dz_out_q  <= 1'b0;
      sat_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        StIdle: begin
          if (div_vld) begin
            num_q   <= num_abs;
            den_q   <= den_abs;
            rem_q   <= '0;
            cnt_q   <= CntW'(pNUM_BW - 1);
            sign_q  <= div_num_pd[pNUM_BW-1] ^ div_den_pd[pDEN_BW-1];
            nsign_q <= div_num_pd[pNUM_BW-1];
            dz_q    <= (div_den_pd == '0);
          end
        end
        StCalc: begin
          num_q <= num_step;
          rem_q <= rem_step;
          cnt_q <= cnt_q - 1'b1;
        end
        StFix: begin
          pd_q      <= fix_q;
          rem_out_q <= fix_rem;
          dz_out_q  <= dz_q;
          sat_q     <= fix_sat;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cdp_dp_div_unit.sv
// Randomized self-checking bench for cdp_dp_div_unit against an integer-arithmetic reference.
module tb_cdp_dp_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        div_vld = 1'b0;
  logic        div_rdy;
  logic [24:0] div_num_pd = '0;
  logic [15:0] div_den_pd = '0;
  logic        div_unit_vld;
  logic        div_unit_rdy = 1'b0;
  logic [24:0] div_unit_pd;
  logic [15:0] div_unit_rem;
  logic        div_unit_dz;
  logic        div_unit_sat;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cdp_dp_div_unit #(.pNUM_BW(25), .pDEN_BW(16)) dut (
    .nvdla_core_clk(clk),
    .nvdla_core_rst(rst),
    .div_vld       (div_vld),
    .div_rdy       (div_rdy),
    .div_num_pd    (div_num_pd),
    .div_den_pd    (div_den_pd),
    .div_unit_vld  (div_unit_vld),
    .div_unit_rdy  (div_unit_rdy),
    .div_unit_pd   (div_unit_pd),
    .div_unit_rem  (div_unit_rem),
    .div_unit_dz   (div_unit_dz),
    .div_unit_sat  (div_unit_sat)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain signed arithmetic on longints.
  task automatic model(input longint n, input longint d, output logic [24:0] q,
                       output logic [15:0] r, output logic dz, output logic sat);
    longint qt, rt, qc;
    if (d == 0) begin
      dz  = 1'b1;
      sat = 1'b0;
      r   = '0;
      q   = (n >= 0) ? 25'(16777215) : 25'(-16777216);
    end else begin
      dz = 1'b0;
      qt = n / d;
      rt = n - qt * d;
`ifdef CDP_DIV_ROUND_EN
      if (2 * (rt < 0 ? -rt : rt) >= (d < 0 ? -d : d)) begin
        qt = qt + (((n < 0) != (d < 0)) ? -1 : 1);
        rt = n - qt * d;
      end
`endif
      qc  = (qt > 16777215) ? 16777215 : (qt < -16777216) ? -16777216 : qt;
      sat = (qc != qt);
      q   = qc[24:0];
      r   = rt[15:0];
    end
  endtask

  task automatic run_op(input logic signed [24:0] n, input logic signed [15:0] d,
                        input int hold, output logic [24:0] opd, output logic [15:0] orem,
                        output longint t_acc);
    logic [24:0] eq;
    logic [15:0] er;
    logic        edz, esat, bad;
    int          lat;
    logic [31:0] rnd;
    model(longint'(n), longint'(d), eq, er, edz, esat);
    @(negedge clk);
    check_val("rdy_idle", div_rdy, 1);
    div_vld    = 1'b1;
    div_num_pd = n;
    div_den_pd = d;
    @(posedge clk);
    t_acc = $time;
    #1;
    div_vld    = 1'b0;
    rnd        = $urandom;
    div_num_pd = rnd[24:0];
    div_den_pd = rnd[31:16];
    lat = 0;
    bad = 1'b0;
    while (!div_unit_vld && lat < 40) begin
      if (div_rdy) bad = 1'b1;
      @(posedge clk);
      #1;
      lat++;
    end
    check_val("latency", lat, 26);
    check_val("rdy_busy", bad, 0);
    check_val("pd", div_unit_pd, eq);
    check_val("rem", div_unit_rem, er);
    check_val("flags", {div_unit_dz, div_unit_sat}, {edz, esat});
    opd  = div_unit_pd;
    orem = div_unit_rem;
    bad  = 1'b0;
    repeat (hold) begin
      div_vld = 1'b1;
      @(posedge clk);
      #1;
      if (!div_unit_vld || div_rdy || div_unit_pd !== eq || div_unit_rem !== er ||
          {div_unit_dz, div_unit_sat} !== {edz, esat}) bad = 1'b1;
    end
    if (hold > 0) check_val("hold_stable", bad, 0);
    div_vld      = 1'b0;
    div_unit_rdy = 1'b1;
    @(posedge clk);
    #1;
    div_unit_rdy = 1'b0;
    check_val("post_hs", {div_unit_vld, div_rdy}, 2'b01);
  endtask

  initial begin
    logic [24:0] pd;
    logic [15:0] rm;
    longint      t0, t1;
    logic        seen;
    logic [31:0] rn, rd;
    logic signed [24:0] n;
    logic signed [15:0] d;

    repeat (3) @(posedge clk);
    #1;
    check_val("reset_out", {div_unit_vld, div_unit_pd, div_unit_rem, div_unit_dz, div_unit_sat}, 0);
    check_val("reset_rdy", div_rdy, 1);
    @(negedge clk);
    rst = 1'b0;

`ifndef CDP_DIV_ROUND_EN
    run_op(25'sd100, 16'sd7, 0, pd, rm, t0);
    check_val("tp_100_7", {pd, rm}, {25'(14), 16'(2)});
    run_op(-25'sd100, 16'sd7, 0, pd, rm, t0);
    check_val("tp_m100_7", {pd, rm}, {25'(-14), 16'(-2)});
    run_op(25'sd100, -16'sd7, 0, pd, rm, t0);
    check_val("tp_100_m7", {pd, rm}, {25'(14 * -1), 16'(2)});
    run_op(-25'sd100, -16'sd7, 0, pd, rm, t0);
    check_val("tp_m100_m7", {pd, rm}, {25'(14), 16'(-2)});
`else
    run_op(25'sd11, 16'sd2, 0, pd, rm, t0);
    check_val("tp_r_11_2", {pd, rm}, {25'(6), 16'(-1)});
    run_op(-25'sd11, 16'sd2, 0, pd, rm, t0);
    check_val("tp_r_m11_2", {pd, rm}, {25'(-6), 16'(1)});
    run_op(25'sd100, 16'sd7, 0, pd, rm, t0);
    check_val("tp_r_100_7", {pd, rm}, {25'(14), 16'(2)});
    run_op(25'sd13, 16'sd7, 0, pd, rm, t0);
    check_val("tp_r_13_7", {pd, rm}, {25'(2), 16'(-1)});
`endif
    run_op(-25'sd16777216, -16'sd1, 0, pd, rm, t0);
    check_val("tp_sat", {pd, rm, div_unit_sat}, {25'(16777215), 16'(0), 1'b1});
    run_op(25'sd5, 16'sd0, 0, pd, rm, t0);
    check_val("tp_dz_pos", {pd, rm, div_unit_dz}, {25'(16777215), 16'(0), 1'b1});
    run_op(-25'sd5, 16'sd0, 10, pd, rm, t0);
    check_val("tp_dz_neg", {pd, div_unit_dz}, {25'(-16777216), 1'b1});

    run_op(25'sd1000, 16'sd3, 0, pd, rm, t0);
    run_op(25'sd999, -16'sd4, 0, pd, rm, t1);
    check_val("b2b_interval", t1 - t0, 280);

    // Abandon an operation mid-CALC; its result must never appear.
    @(negedge clk);
    div_vld    = 1'b1;
    div_num_pd = 25'(12345);
    div_den_pd = 16'(7);
    @(posedge clk);
    #1;
    div_vld = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_val("rst_clear", {div_unit_vld, div_unit_pd, div_unit_rem, div_unit_dz, div_unit_sat}, 0);
    check_val("rst_rdy", div_rdy, 1);
    @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (div_unit_vld) seen = 1'b1;
    end
    check_val("rst_no_result", seen, 0);
    run_op(25'sd9, 16'sd3, 0, pd, rm, t0);
    check_val("tp_9_3", {pd, rm}, {25'(3), 16'(0)});

    for (int i = 0; i < 60; i++) begin
      rn = $urandom;
      rd = $urandom;
      n  = rn[24:0];
      case (rd[31:30])
        2'd0:    d = 16'($signed(rd[3:0]));
        2'd1:    d = 16'($signed(rd[8:0]));
        default: d = rd[15:0];
      endcase
      if (rd[29:26] == 4'd0) n = -25'sd16777216;
      if (rd[25:22] == 4'd0) n = 25'($signed(rn[6:0]));
      run_op(n, d, int'(rd[21:20]), pd, rm, t0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
